// File: rtl/cpa_pkg.sv
// Shared constants, operand type and segment-geometry helpers for the
// pipelined carry-propagate adder.
package cpa_pkg;

   localparam int CPA_WIDTH = 178;

   typedef logic [CPA_WIDTH-1:0] cpa_word_t;

   // Every segment is ceil(width/seg) wide except the last, which takes the remainder.
   function automatic int seg_width(input int width, input int seg, input int k);
      int sw;
      sw = (width + seg - 1) / seg;
      return (k < seg - 1) ? sw : width - sw * (seg - 1);
   endfunction

   function automatic int seg_lsb(input int width, input int seg, input int k);
      return k * ((width + seg - 1) / seg);
   endfunction

endpackage

// File: rtl/cpa_seg.sv
// One carry-propagate segment: adds its operand slices plus the incoming carry
// and registers sum, carry-out and valid under the global advance enable.
module cpa_seg
   import cpa_pkg::*;
#(
   parameter int SW = 45
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv,
   input  logic          in_valid,
   input  logic [SW-1:0] in_a,
   input  logic [SW-1:0] in_b,
   input  logic          in_cin,
   output logic          out_valid,
   output logic [SW-1:0] out_sum,
   output logic          out_cout
);

   logic          valid_d, valid_q;
   logic [SW-1:0] sum_d, sum_q;
   logic          cout_d, cout_q;
   logic [SW:0]   add;

   // Data only loads behind a valid item, so bubbles never drag X through.
   always_comb begin
      add     = {1'b0, in_a} + {1'b0, in_b} + {{SW{1'b0}}, in_cin};
      valid_d = valid_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      if (adv) begin
         valid_d = in_valid;
         if (in_valid) begin
            sum_d  = add[SW-1:0];
            cout_d = add[SW];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign out_valid = valid_q;
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;

endmodule

// File: rtl/csa_cpa_pipe.sv
// SEG-stage pipelined carry-propagate adder resolving a carry-save (c, s) pair.
// Build option CPA_TAG_EN adds a sideband tag that travels with each result.
module csa_cpa_pipe
   import cpa_pkg::*;
#(
   parameter int WIDTH = CPA_WIDTH,
   parameter int SEG   = 4
`ifdef CPA_TAG_EN
   ,parameter int TAG_W = 8
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_c,
   input  logic [WIDTH-1:0] in_s,
`ifdef CPA_TAG_EN
   input  logic [TAG_W-1:0] in_tag,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef CPA_TAG_EN
   ,output logic [TAG_W-1:0] out_tag
`endif
);

   // Handshake: a word moves in when in_valid && in_ready and out when
   // out_valid && out_ready; the whole pipe advances together when the output
   // slot is empty or being drained, so in_ready is combinational on out_ready.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < SEG; k++) begin : g_st
      localparam int LSB = seg_lsb(WIDTH, SEG, k);
      localparam int SWK = seg_width(WIDTH, SEG, k);
      localparam int RW  = WIDTH - LSB;

      logic               vin;
      logic               cin;
      logic [RW-1:0]      rem_c, rem_s;
      logic               vout;
      logic [SWK-1:0]     sum;
      logic               cout;
      logic [LSB+SWK-1:0] done;
`ifdef CPA_TAG_EN
      logic [TAG_W-1:0]   tag_in, tag_d, tag_q;
`endif

      if (k == 0) begin : g_src
         assign vin   = in_valid;
         assign cin   = 1'b0;
         assign rem_c = in_c;
         assign rem_s = in_s;
         assign done  = sum;
`ifdef CPA_TAG_EN
         assign tag_in = in_tag;
`endif
      end else begin : g_src
         // Finished low result segments, deskewed alongside this stage's sum.
         logic [LSB-1:0] lo_d, lo_q;

         assign vin   = g_st[k-1].vout;
         assign cin   = g_st[k-1].cout;
         assign rem_c = g_st[k-1].g_hi.c_hi_q;
         assign rem_s = g_st[k-1].g_hi.s_hi_q;
         assign done  = {sum, lo_q};
`ifdef CPA_TAG_EN
         assign tag_in = g_st[k-1].tag_q;
`endif

         always_comb begin
            lo_d = lo_q;
            if (adv && vin) lo_d = g_st[k-1].done;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) lo_q <= '0;
            else     lo_q <= lo_d;
         end
      end

      cpa_seg #(
         .SW (SWK)
      ) u_seg (
         .clk       (clk),
         .rst       (rst),
         .adv       (adv),
         .in_valid  (vin),
         .in_a      (rem_c[SWK-1:0]),
         .in_b      (rem_s[SWK-1:0]),
         .in_cin    (cin),
         .out_valid (vout),
         .out_sum   (sum),
         .out_cout  (cout)
      );

      if (k < SEG - 1) begin : g_hi
         // Operand segments not yet consumed, skewed one stage per segment.
         localparam int HW = RW - SWK;
         logic [HW-1:0] c_hi_d, c_hi_q, s_hi_d, s_hi_q;

         always_comb begin
            c_hi_d = c_hi_q;
            s_hi_d = s_hi_q;
            if (adv && vin) begin
               c_hi_d = rem_c[RW-1:SWK];
               s_hi_d = rem_s[RW-1:SWK];
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               c_hi_q <= '0;
               s_hi_q <= '0;
            end else begin
               c_hi_q <= c_hi_d;
               s_hi_q <= s_hi_d;
            end
         end
      end

`ifdef CPA_TAG_EN
      always_comb begin
         tag_d = tag_q;
         if (adv && vin) tag_d = tag_in;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) tag_q <= '0;
         else     tag_q <= tag_d;
      end
`endif
   end

   assign out_valid = g_st[SEG-1].vout;
   assign out_sum   = g_st[SEG-1].done;
   assign out_cout  = g_st[SEG-1].cout;
`ifdef CPA_TAG_EN
   assign out_tag   = g_st[SEG-1].tag_q;
`endif

endmodule

// File: tb/tb_csa_cpa_pipe.sv
// Directed + randomized bench for csa_cpa_pipe against an arithmetic reference
// model; builds with or without CPA_TAG_EN.
module tb_csa_cpa_pipe;
   import cpa_pkg::*;

   localparam int WIDTH = CPA_WIDTH;
   localparam int SEG   = 4;
`ifdef CPA_TAG_EN
   localparam int TAG_W = 8;
`else
   localparam int TAG_W = 0;
`endif
   localparam int EW = 1 + WIDTH + TAG_W;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   cpa_word_t        in_c;
   cpa_word_t        in_s;
   logic             out_valid;
   logic             out_ready;
   cpa_word_t        out_sum;
   logic             out_cout;
`ifdef CPA_TAG_EN
   logic [7:0]       in_tag;
   logic [7:0]       out_tag;
`endif

   logic [EW-1:0]    exp_q[$];
   int               acc_q[$];
   int               total;
   int               bad;
   int               cyc;
   bit               lat_en;
   logic [EW-1:0]    snap;
   cpa_word_t        one_w;

   csa_cpa_pipe #(
      .WIDTH (WIDTH),
      .SEG   (SEG)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_c      (in_c),
      .in_s      (in_s),
`ifdef CPA_TAG_EN
      .in_tag    (in_tag),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
`ifdef CPA_TAG_EN
      ,.out_tag  (out_tag)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", name, obs, expv);
      end
   endtask

   function automatic cpa_word_t rnd_word();
      cpa_word_t w;
      w = '0;
      for (int i = 0; i < 6; i++) w = (w << 32) | cpa_word_t'($urandom());
      return w;
   endfunction

   // Reference: plain (WIDTH+1)-bit addition, cout on top, tag below.
   function automatic logic [EW-1:0] model(input cpa_word_t c, input cpa_word_t s);
      logic [WIDTH:0] full;
      full = {1'b0, c} + {1'b0, s};
`ifdef CPA_TAG_EN
      return {full, in_tag};
`else
      return full;
`endif
   endfunction

   function automatic logic [EW-1:0] obs_word();
`ifdef CPA_TAG_EN
      return {out_cout, out_sum, out_tag};
`else
      return {out_cout, out_sum};
`endif
   endfunction

   // One clock: sample handshakes mid-cycle, score, then step past the edge.
   task automatic tick();
      bit acc;
      bit done;
      int a;
      #2;
      acc  = in_valid && in_ready;
      done = out_valid && out_ready;
      if (done) begin
         chk("no_extra_result", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            chk("result", obs_word(), exp_q.pop_front());
            a = acc_q.pop_front();
            if (lat_en) chk("latency", cyc - a, SEG);
         end
      end
      if (acc) begin
         exp_q.push_back(model(in_c, in_s));
         acc_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input cpa_word_t c, input cpa_word_t s);
      in_valid = 1'b1;
      in_c     = c;
      in_s     = s;
`ifdef CPA_TAG_EN
      in_tag   = 8'($urandom());
`endif
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      cyc       = 0;
      lat_en    = 1'b1;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_c      = '0;
      in_s      = '0;
      out_ready = 1'b1;
      one_w     = 1;
`ifdef CPA_TAG_EN
      in_tag    = '0;
`endif

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_sum", out_sum, 0);
      chk("reset_out_cout", out_cout, 0);
`ifdef CPA_TAG_EN
      chk("reset_out_tag", out_tag, 0);
`endif
      rst = 1'b0;
      chk("in_ready_after_reset", in_ready, 1);

      // directed: small sum, full ripple, segment-boundary carry
      send(cpa_word_t'(2), cpa_word_t'(3));
      drain(20);
      send(cpa_word_t'(2), ~cpa_word_t'(0));
      drain(20);
      send(cpa_word_t'(2), (one_w << 45) - one_w);
      drain(20);

      // back-to-back throughput
      for (int i = 0; i < 20; i++) send(rnd_word(), rnd_word());
      drain(20);

      // stall hold with four results queued
      for (int i = 0; i < 4; i++) send(rnd_word(), rnd_word());
      out_ready = 1'b0;
      lat_en    = 1'b0;
      in_valid  = 1'b1;
      in_c      = rnd_word();
      in_s      = rnd_word();
      #2;
      snap = obs_word();
      chk("stall_out_valid", out_valid, 1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #3;
         cyc++;
         chk("stall_in_ready", in_ready, 0);
         chk("stall_out_valid_hold", out_valid, 1);
         chk("stall_data_hold", obs_word(), snap);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      out_ready = 1'b1;
      drain(20);

      // random valid / backpressure mix
      for (int i = 0; i < 60; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_c      = rnd_word();
         in_s      = rnd_word();
`ifdef CPA_TAG_EN
         in_tag    = 8'($urandom());
`endif
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain(60);

      // reset mid-flight
      lat_en = 1'b1;
      for (int i = 0; i < 3; i++) send(rnd_word(), rnd_word());
      tick();
      chk("pre_reset_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_out_sum", out_sum, 0);
      chk("midreset_out_cout", out_cout, 0);
      exp_q.delete();
      acc_q.delete();
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
      repeat (6) tick();
      send(rnd_word(), rnd_word());
      drain(20);

      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/csa_cpa_pipe.md
Name: csa_cpa_pipe

Overview:
- Pipelined carry-propagate adder sitting directly downstream of the 178-bit carry-save adder in the 89x89 multiplier datapath.
- Consumes the redundant (c, s) pair and resolves it into a binary 178-bit product word plus carry-out.
- The carry chain is split into SEG segments, one register stage each, so the critical path is one segment adder.
- Full valid/ready handshake so the downstream modular reduction stage can stall it.

Parameters:
- WIDTH, 178, operand and result width in bits.
- SEG, 4, number of pipeline segments (1..8). Segment width SW = ceil(WIDTH/SEG); the last segment takes the remainder (4 segments: 45,45,45,43).
- TAG_W, 8, width of the optional sideband tag (only used with CPA_TAG_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  c/s pair valid.
- in_ready  out  1  stage can accept this cycle.
- in_c  in  WIDTH  carry vector from the CSA. Bit 0 is expected 0; any value is added.
- in_s  in  WIDTH  sum vector from the CSA.
- in_tag  in  TAG_W  sideband tag (CPA_TAG_EN only).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_sum  out  WIDTH  (in_c + in_s) mod 2^WIDTH.
- out_cout  out  1  bit WIDTH of in_c + in_s.
- out_tag  out  TAG_W  tag matching out_sum (CPA_TAG_EN only).

Behaviour:
- Global advance: adv = !out_valid || out_ready. All stage registers load only when adv=1.
- in_ready = adv. This is combinational from out_ready; there is no skid buffer.
- Transfer occurs when in_valid && in_ready. Output handshake completes when out_valid && out_ready.
- Stage k (0..SEG-1):
  - Adds segment k of c and s plus the carry registered by stage k-1 (stage 0 uses carry-in 0).
  - Registers the segment result, the segment carry-out and a valid bit.
  - Passes higher operand segments and lower finished result segments forward unchanged (skew/deskew registers).
- Latency: exactly SEG cycles from an accepted input to out_valid, when out_ready is held high. Throughput is 1 per cycle.
- Bubbles are not collapsed. While adv=1 a stage whose predecessor is empty loads valid=0.
- Stall (adv=0): every register holds. out_sum, out_cout and out_valid stay stable until accepted.
- out_cout is the final-stage segment carry-out. It is not masked.
- Reset, including mid-operation:
  - All valid bits clear immediately and in-flight data is discarded.
  - out_valid=0, out_sum=0, out_cout=0, out_tag=0.
  - in_ready=1 one cycle after reset deasserts (it is combinationally 1 while out_valid=0).
- Data registers may be left unreset for area, except the output registers, which reset to 0.
- SEG=1 degenerates to a single registered full-width adder with latency 1.
- No X propagation: data registers load only when their stage's incoming valid is 1, otherwise they hold.

Optional Feature:
- Macro: CPA_TAG_EN.
- Defined: in_tag is captured with the accepted input and travels through a SEG-deep tag pipeline under the same adv enable. out_tag presents alongside out_sum and resets to 0.
- Undefined: in_tag and out_tag ports are absent and no tag registers are built. All other behaviour is identical.

Decomposition:
- Package cpa_pkg:
  - CPA_WIDTH=178 constant.
  - Function seg_width(WIDTH, SEG, k) returning the segment width.
  - Function seg_lsb(WIDTH, SEG, k) returning the segment LSB index.
  - Typedef for the 178-bit operand word.
- Sub-module cpa_seg: one segment adder with its stage registers (result, carry, valid), parameterised by segment width.
- csa_cpa_pipe instantiates SEG copies of cpa_seg via generate and adds the skew/deskew shift registers.

Test Plan:
- Reset value and single transfer: rst high, check out_valid=0 and out_sum=0. Then in_c=2, in_s=3 with out_ready=1, expect out_sum=5, out_cout=0 exactly 4 cycles after acceptance.
- Full carry ripple across all segments: in_s=2^178-1, in_c=2, expect out_sum=1, out_cout=1.
- Segment-boundary carry: in_s=2^45-1, in_c=2^1, expect out_sum=2^45+1, out_cout=0.
- Back-to-back throughput: 20 random pairs on consecutive cycles with out_ready=1. Expect 20 results in order on consecutive cycles, matching a reference model. Check out_tag order with CPA_TAG_EN.
- Stall hold: hold out_ready=0 for 6 cycles while out_valid=1. Expect in_ready=0, and out_sum and out_cout stable. Release and expect no loss or duplication of the 4 queued results.
- Reset mid-flight: accept 3 inputs, assert rst for 1 cycle. Expect out_valid=0 at once and no stale result afterwards. The next input returns its correct sum with latency 4.
